// File: rtl/dwc_upconv_precalc_achan_fifo.sv
// Address-channel pre-calculation FIFO for the AXI4 data-width up-converter.
// Derives the wrap-split and wide-burst length fields on push and queues them with the beat.
module dwc_upconv_precalc_achan_fifo #(
  parameter int DATA_WIDTH_IN  = 32,
  parameter int DATA_WIDTH_OUT = 128,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int USER_WIDTH     = 1,
  parameter int DEPTH          = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid_in,
  output logic                  a_ready_out,
  input  logic [ID_WIDTH-1:0]   a_id_in,
  input  logic [ADDR_WIDTH-1:0] a_addr_in,
  input  logic [7:0]            a_len_in,
  input  logic [2:0]            a_size_in,
  input  logic [1:0]            a_burst_in,
  input  logic [1:0]            a_lock_in,
  input  logic [3:0]            a_cache_in,
  input  logic [2:0]            a_prot_in,
  input  logic [3:0]            a_qos_in,
  input  logic [3:0]            a_region_in,
  input  logic [USER_WIDTH-1:0] a_user_in,
  output logic                  a_valid_out,
  input  logic                  a_ready_in,
  output logic [ID_WIDTH-1:0]   a_id_out,
  output logic [ADDR_WIDTH-1:0] a_addr_out,
  output logic [7:0]            a_len_out,
  output logic [2:0]            a_size_out,
  output logic [1:0]            a_burst_out,
  output logic [1:0]            a_lock_out,
  output logic [3:0]            a_cache_out,
  output logic [2:0]            a_prot_out,
  output logic [3:0]            a_qos_out,
  output logic [3:0]            a_region_out,
  output logic [USER_WIDTH-1:0] a_user_out,
  output logic [4:0]            to_boundary_out,
  output logic [11:0]           mask_wrap_addr_out,
  output logic [2:0]            size_diff_out,
  output logic [6:0]            len_offset_out,
  output logic                  wrap_split_out,
  output logic                  fixed_out,
  output logic [7:0]            alen_wrap_out,
  output logic [7:0]            alen_sec_wrap_out,
  output logic [7:0]            out_len_out,
  output logic [3:0]            count_out
);

  localparam int LOG_OUT = $clog2(DATA_WIDTH_OUT / 8);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [6:0]       OFF_MASK = 7'((DATA_WIDTH_OUT / 8) - 1);
  localparam logic [1:0]       BURST_FIXED = 2'b00;
  localparam logic [1:0]       BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [1:0]            lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [USER_WIDTH-1:0] user;
    logic [4:0]            to_boundary;
    logic [11:0]           mask_wrap_addr;
    logic [2:0]            size_diff;
    logic [6:0]            len_offset;
    logic                  wrap_split;
    logic                  fixed;
    logic [7:0]            alen_wrap;
    logic [7:0]            alen_sec_wrap;
    logic [7:0]            out_len;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           new_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [3:0]       count;
  logic [3:0]       count_next;
  logic             push;
  logic             pop;

  logic [11:0] len_p1;
  logic [3:0]  addr_beat;
  logic [8:0]  incr_sum;

  // Field pre-calculation, purely combinational on the incoming beat.
  always_comb begin
    new_entry        = '0;
    new_entry.id     = a_id_in;
    new_entry.addr   = a_addr_in;
    new_entry.len    = a_len_in;
    new_entry.size   = a_size_in;
    new_entry.burst  = a_burst_in;
    new_entry.lock   = a_lock_in;
    new_entry.cache  = a_cache_in;
    new_entry.prot   = a_prot_in;
    new_entry.qos    = a_qos_in;
    new_entry.region = a_region_in;
    new_entry.user   = a_user_in;

    new_entry.size_diff      = 3'(LOG_OUT) - a_size_in;
    len_p1                   = 12'(a_len_in) + 12'd1;
    new_entry.mask_wrap_addr = (len_p1 << a_size_in) - 12'd1;
    new_entry.wrap_split     = ((a_addr_in[11:0] & new_entry.mask_wrap_addr) != '0)
                               && (a_burst_in == BURST_WRAP);
    new_entry.fixed          = (a_burst_in == BURST_FIXED);

    // Beat index inside the wrap window; the window is at most 16 beats.
    addr_beat                = 4'(a_addr_in[10:0] >> a_size_in) & a_len_in[3:0];
    new_entry.to_boundary    = 5'(a_len_in) + 5'd1 - 5'(addr_beat);
    new_entry.alen_wrap      = (8'(new_entry.to_boundary) - 8'd1) >> new_entry.size_diff;
    new_entry.alen_sec_wrap  = (a_len_in - 8'(new_entry.to_boundary)) >> new_entry.size_diff;
    new_entry.len_offset     = (a_addr_in[6:0] & OFF_MASK) >> a_size_in;

    incr_sum = 9'(new_entry.len_offset) + 9'(a_len_in);
    case (a_burst_in)
      BURST_FIXED: new_entry.out_len = a_len_in;
      BURST_WRAP:  new_entry.out_len = a_len_in >> new_entry.size_diff;
      default:     new_entry.out_len = 8'(incr_sum >> new_entry.size_diff);
    endcase
  end

  assign push = a_valid_in && a_ready_out;
  assign pop  = a_valid_out && a_ready_in;

  // NOTE: every always_comb output gets a value before any branch, so no latch is inferred.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 4'd1;
      2'b01:   count_next = count - 4'd1;
      default: count_next = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      a_ready_out <= 1'b0;
    end else begin
      count       <= count_next;
      a_ready_out <= (count_next < 4'(DEPTH));
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage has no reset; count gates validity, so stale contents are never consumed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  assign head        = mem[rd_ptr];
  assign a_valid_out = (count != '0);
  assign count_out   = count;

  assign a_id_out           = head.id;
  assign a_addr_out         = head.addr;
  assign a_len_out          = head.len;
  assign a_size_out         = head.size;
  assign a_burst_out        = head.burst;
  assign a_lock_out         = head.lock;
  assign a_cache_out        = head.cache;
  assign a_prot_out         = head.prot;
  assign a_qos_out          = head.qos;
  assign a_region_out       = head.region;
  assign a_user_out         = head.user;
  assign to_boundary_out    = head.to_boundary;
  assign mask_wrap_addr_out = head.mask_wrap_addr;
  assign size_diff_out      = head.size_diff;
  assign len_offset_out     = head.len_offset;
  assign wrap_split_out     = head.wrap_split;
  assign fixed_out          = head.fixed;
  assign alen_wrap_out      = head.alen_wrap;
  assign alen_sec_wrap_out  = head.alen_sec_wrap;
  assign out_len_out        = head.out_len;

endmodule

// File: tb/tb_dwc_upconv_precalc_achan_fifo.sv
// Bench for the up-converter address pre-calculation FIFO (32->128 bit, DEPTH 4).
// Hand vectors, full/reset corner sequences, and randomized traffic against a queue model.
module tb_dwc_upconv_precalc_achan_fifo;

  localparam int DEPTH = 4;

  logic        clk, rst;
  logic        a_valid_in, a_ready_out, a_valid_out, a_ready_in;
  logic [3:0]  a_id_in, a_id_out;
  logic [31:0] a_addr_in, a_addr_out;
  logic [7:0]  a_len_in, a_len_out;
  logic [2:0]  a_size_in, a_size_out;
  logic [1:0]  a_burst_in, a_burst_out;
  logic [1:0]  a_lock_in, a_lock_out;
  logic [3:0]  a_cache_in, a_cache_out;
  logic [2:0]  a_prot_in, a_prot_out;
  logic [3:0]  a_qos_in, a_qos_out;
  logic [3:0]  a_region_in, a_region_out;
  logic [0:0]  a_user_in, a_user_out;
  logic [4:0]  to_boundary_out;
  logic [11:0] mask_wrap_addr_out;
  logic [2:0]  size_diff_out;
  logic [6:0]  len_offset_out;
  logic        wrap_split_out, fixed_out;
  logic [7:0]  alen_wrap_out, alen_sec_wrap_out, out_len_out;
  logic [3:0]  count_out;

  dwc_upconv_precalc_achan_fifo #(
    .DATA_WIDTH_IN(32), .DATA_WIDTH_OUT(128), .ADDR_WIDTH(32),
    .ID_WIDTH(4), .USER_WIDTH(1), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .a_valid_in(a_valid_in), .a_ready_out(a_ready_out),
    .a_id_in(a_id_in), .a_addr_in(a_addr_in), .a_len_in(a_len_in),
    .a_size_in(a_size_in), .a_burst_in(a_burst_in),
    .a_lock_in(a_lock_in), .a_cache_in(a_cache_in), .a_prot_in(a_prot_in),
    .a_qos_in(a_qos_in), .a_region_in(a_region_in), .a_user_in(a_user_in),
    .a_valid_out(a_valid_out), .a_ready_in(a_ready_in),
    .a_id_out(a_id_out), .a_addr_out(a_addr_out), .a_len_out(a_len_out),
    .a_size_out(a_size_out), .a_burst_out(a_burst_out),
    .a_lock_out(a_lock_out), .a_cache_out(a_cache_out), .a_prot_out(a_prot_out),
    .a_qos_out(a_qos_out), .a_region_out(a_region_out), .a_user_out(a_user_out),
    .to_boundary_out(to_boundary_out), .mask_wrap_addr_out(mask_wrap_addr_out),
    .size_diff_out(size_diff_out), .len_offset_out(len_offset_out),
    .wrap_split_out(wrap_split_out), .fixed_out(fixed_out),
    .alen_wrap_out(alen_wrap_out), .alen_sec_wrap_out(alen_sec_wrap_out),
    .out_len_out(out_len_out), .count_out(count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } cmd_t;

  typedef struct {
    cmd_t c;
    int   mask, tb, split, aw, asec, lo, ol, fixed, sd;
  } exp_t;

  typedef struct {
    logic [1:0]  burst;
    int          len, size;
    logic [31:0] addr;
    int          mask, tb, split, aw, asec, lo, ol, fixed, sd;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  cmd_t cur;
  exp_t q[$];
  vec_t vt[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the field definitions, 128-bit bus = 16 bytes.
  function automatic exp_t model(input cmd_t c);
    exp_t        e;
    int          len, sz, beat;
    int unsigned a;
    len     = int'(c.len);
    sz      = int'(c.size);
    a       = c.addr;
    e.c     = c;
    e.sd    = 4 - sz;
    e.mask  = (((len + 1) << sz) - 1) % 4096;
    e.split = (c.burst == 2'b10 && ((a % 4096) & e.mask) != 0) ? 1 : 0;
    e.fixed = (c.burst == 2'b00) ? 1 : 0;
    beat    = int'((a >> sz) % 16) & (len % 16);
    e.tb    = (len + 1 - beat) % 32;
    e.aw    = ((e.tb - 1 + 256) % 256) >> e.sd;
    e.asec  = ((len - e.tb + 256) % 256) >> e.sd;
    e.lo    = int'(a % 16) >> sz;
    if (c.burst == 2'b00)      e.ol = len;
    else if (c.burst == 2'b10) e.ol = len >> e.sd;
    else                       e.ol = (((e.lo + len) % 512) >> e.sd) % 256;
    return e;
  endfunction

  function automatic cmd_t mk(input logic [1:0] burst, input int len, input int size,
                              input logic [31:0] addr, input logic [3:0] id);
    cmd_t c;
    c.id = id; c.addr = addr; c.len = 8'(len); c.size = 3'(size); c.burst = burst;
    c.lock = id[1:0]; c.cache = ~id; c.prot = id[2:0]; c.qos = id + 4'd1;
    c.region = id ^ 4'h5; c.user = id[0];
    return c;
  endfunction

  function automatic cmd_t rnd_cmd();
    int len;
    int wl[5] = '{0, 1, 3, 7, 15};
    len = ($urandom_range(0, 1) == 0) ? wl[$urandom_range(0, 4)] : int'($urandom_range(0, 255));
    return mk(2'($urandom_range(0, 2)), len, int'($urandom_range(0, 2)), $urandom, 4'($urandom));
  endfunction

  task automatic apply(input logic v, input cmd_t c);
    cur = c;
    a_valid_in = v; a_id_in = c.id; a_addr_in = c.addr; a_len_in = c.len;
    a_size_in = c.size; a_burst_in = c.burst; a_lock_in = c.lock; a_cache_in = c.cache;
    a_prot_in = c.prot; a_qos_in = c.qos; a_region_in = c.region; a_user_in = c.user;
  endtask

  task automatic check_head(input exp_t e, input string t);
    check({t, " id"}, a_id_out, e.c.id);
    check({t, " addr"}, a_addr_out, e.c.addr);
    check({t, " len"}, a_len_out, e.c.len);
    check({t, " size"}, a_size_out, e.c.size);
    check({t, " burst"}, a_burst_out, e.c.burst);
    check({t, " side"}, {a_lock_out, a_cache_out, a_prot_out, a_qos_out, a_region_out, a_user_out},
          {e.c.lock, e.c.cache, e.c.prot, e.c.qos, e.c.region, e.c.user});
    check({t, " mask"}, mask_wrap_addr_out, e.mask);
    check({t, " to_boundary"}, to_boundary_out, e.tb);
    check({t, " wrap_split"}, wrap_split_out, e.split);
    check({t, " fixed"}, fixed_out, e.fixed);
    check({t, " size_diff"}, size_diff_out, e.sd);
    check({t, " len_offset"}, len_offset_out, e.lo);
    check({t, " alen_wrap"}, alen_wrap_out, e.aw);
    if (e.split == 1) check({t, " alen_sec_wrap"}, alen_sec_wrap_out, e.asec);
    if (e.split == 0) check({t, " out_len"}, out_len_out, e.ol);
  endtask

  // Scoreboard the transfers the coming edge will perform, then advance to the next negedge.
  task automatic cycle();
    check("count", count_out, q.size());
    check("valid_out", a_valid_out, q.size() != 0);
    check("ready_out", a_ready_out, q.size() < DEPTH);
    if (a_valid_out && a_ready_in) begin
      if (q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL pop_underflow: got pop expected empty model");
      end else begin
        check_head(q[0], "sb");
        void'(q.pop_front());
      end
    end
    if (a_valid_in && a_ready_out) q.push_back(model(cur));
    @(negedge clk);
  endtask

  task automatic drain();
    a_valid_in = 1'b0;
    a_ready_in = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) cycle();
    check("drain empty", q.size(), 0);
    check("drain valid_out", a_valid_out, 1'b0);
    a_ready_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // burst len size addr | mask tb split aw asec lo ol fixed sd
    vt[0] = '{2'b10,   3, 2, 32'h0000_0100, 12'h00F,  4, 0, 0, 63,  0,  0, 0, 2};
    vt[1] = '{2'b10,   3, 2, 32'h0000_0108, 12'h00F,  2, 1, 0,  0,  2,  0, 0, 2};
    vt[2] = '{2'b01,   7, 2, 32'h0000_000C, 12'h01F,  5, 0, 1,  0,  3,  2, 0, 2};
    vt[3] = '{2'b00,   5, 2, 32'h0000_0010, 12'h017,  2, 0, 0,  0,  0,  5, 1, 2};
    vt[4] = '{2'b10,   7, 1, 32'h0000_1006, 12'h00F,  5, 1, 0,  0,  3,  0, 0, 3};
    vt[5] = '{2'b01, 255, 0, 32'h0000_000F, 12'h0FF, 17, 0, 1, 14, 15, 16, 0, 4};
    vt[6] = '{2'b10,  15, 2, 32'h0000_003C, 12'h03F,  1, 1, 0,  3,  3,  3, 0, 2};

    rst = 1'b1;
    a_ready_in = 1'b0;
    apply(1'b0, mk(2'b01, 0, 0, 32'h0, 4'h0));
    @(negedge clk);
    check("reset valid_out", a_valid_out, 1'b0);
    check("reset ready_out", a_ready_out, 1'b0);
    check("reset count", count_out, 0);
    rst = 1'b0;
    #1 check("release ready_out low", a_ready_out, 1'b0);
    @(negedge clk);
    check("release ready_out high", a_ready_out, 1'b1);

    // Directed vectors: single beat through an empty FIFO, one-cycle latency.
    for (int i = 0; i < 7; i++) begin
      apply(1'b1, mk(vt[i].burst, vt[i].len, vt[i].size, vt[i].addr, 4'(i)));
      cycle();
      a_valid_in = 1'b0;
      check($sformatf("vec%0d valid", i), a_valid_out, 1'b1);
      check($sformatf("vec%0d mask", i), mask_wrap_addr_out, vt[i].mask);
      check($sformatf("vec%0d to_boundary", i), to_boundary_out, vt[i].tb);
      check($sformatf("vec%0d wrap_split", i), wrap_split_out, vt[i].split);
      check($sformatf("vec%0d fixed", i), fixed_out, vt[i].fixed);
      check($sformatf("vec%0d size_diff", i), size_diff_out, vt[i].sd);
      check($sformatf("vec%0d len_offset", i), len_offset_out, vt[i].lo);
      check($sformatf("vec%0d alen_wrap", i), alen_wrap_out, vt[i].aw);
      if (vt[i].split == 1) check($sformatf("vec%0d alen_sec", i), alen_sec_wrap_out, vt[i].asec);
      else                  check($sformatf("vec%0d out_len", i), out_len_out, vt[i].ol);
      a_ready_in = 1'b1;
      cycle();
      a_ready_in = 1'b0;
    end

    // Full: five back-to-back beats with the consumer stalled.
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, mk(2'b01, i + 1, 2, 32'h2000 + 32'(i * 4), 4'(8 + i)));
      if (i == 4) begin
        check("full ready_out", a_ready_out, 1'b0);
        check("full count", count_out, 4);
        a_ready_in = 1'b1;
      end
      cycle();
    end
    a_ready_in = 1'b0;
    check("after pop count", count_out, 3);
    check("after pop ready_out", a_ready_out, 1'b1);
    cycle();
    a_valid_in = 1'b0;
    check("refill count", count_out, 4);
    drain();

    // Steady state at occupancy 2 with a push and a pop every cycle.
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, mk(2'b10, 3, 2, 32'h3000 + 32'(i * 8), 4'(i)));
      cycle();
    end
    a_ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, mk(2'b01, i, 1, 32'h4000 + 32'(i * 6), 4'(i + 2)));
      cycle();
      check("pushpop count", count_out, 2);
    end
    drain();

    // Asynchronous reset while three entries are queued.
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, mk(2'b00, i, 2, 32'h5000 + 32'(i * 4), 4'(i)));
      cycle();
    end
    a_valid_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async valid_out", a_valid_out, 1'b0);
    check("async count", count_out, 0);
    check("async ready_out", a_ready_out, 1'b0);
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("rerelease ready_out low", a_ready_out, 1'b0);
    @(negedge clk);
    check("rerelease ready_out high", a_ready_out, 1'b1);
    apply(1'b1, mk(2'b01, 2, 2, 32'h6004, 4'hD));
    cycle();
    a_valid_in = 1'b0;
    check("post reset head id", a_id_out, 4'hD);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 9) < 7, rnd_cmd());
      a_ready_in = ($urandom_range(0, 9) < 6);
      cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dwc_upconv_precalc_achan_fifo.md
Name: dwc_upconv_precalc_achan_fifo

Overview:
- Parametrised address-channel pre-calculation buffer for the AXI4 data-width up-converter.
- Accepts an AW or AR beat from the narrow master side and computes the wrap-split and length fields the command-FIFO write controller needs, for any input/output width pair.
- Stores the beat plus the computed fields in a DEPTH-entry FIFO.
- Replaces the single-entry hold-register slice, so back-to-back commands are accepted at full rate.

Parameters:
- DATA_WIDTH_IN, 32, master-side data width in bits (8..1024, power of 2).
- DATA_WIDTH_OUT, 128, slave-side data width in bits (>= DATA_WIDTH_IN, power of 2).
- ADDR_WIDTH, 32, address width (>= 12).
- ID_WIDTH, 4, ID width.
- USER_WIDTH, 1, user width.
- DEPTH, 2, FIFO entries (2, 4 or 8).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- a_valid_in  in  1  source command valid.
- a_ready_out  out  1  ready to source.
- a_id_in / a_addr_in / a_len_in / a_size_in / a_burst_in  in  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2  command fields.
- a_lock_in / a_cache_in / a_prot_in / a_qos_in / a_region_in / a_user_in  in  2 / 4 / 3 / 4 / 4 / USER_WIDTH  sideband.
- a_valid_out  out  1  entry available.
- a_ready_in  in  1  consumer pop.
- a_*_out  out  same widths as the a_*_in fields  stored command.
- to_boundary_out  out  5  beats to wrap boundary.
- mask_wrap_addr_out  out  12  wrap address mask.
- size_diff_out  out  3  log2 width ratio for this beat.
- len_offset_out  out  7  narrow-beat offset within first wide beat.
- wrap_split_out  out  1  unaligned WRAP, needs two wide bursts.
- fixed_out  out  1  burst == FIXED.
- alen_wrap_out  out  8  first wide burst length - 1.
- alen_sec_wrap_out  out  8  second wide burst length - 1.
- out_len_out  out  8  wide burst length - 1 for non-split bursts.
- count_out  out  4  occupancy.

Behaviour:
- LOG_OUT = clog2(DATA_WIDTH_OUT/8). a_size_in <= clog2(DATA_WIDTH_IN/8) is guaranteed by upstream.
- Computations are combinational on the input fields and written into the FIFO on push:
  - size_diff = LOG_OUT - a_size_in.
  - mask_wrap_addr = ((a_len_in+1) << a_size_in) - 1, truncated to 12 bits.
  - unaligned = (a_addr_in[11:0] & mask_wrap_addr) != 0.
  - wrap_split = unaligned & (burst == 2'b10).
  - fixed = (burst == 2'b00).
  - addr_beat = (a_addr_in >> a_size_in)[3:0] & a_len_in[3:0].
  - to_boundary = a_len_in + 1 - addr_beat, 5 bits.
  - alen_wrap = (to_boundary - 1) >> size_diff.
  - alen_sec_wrap = (a_len_in - to_boundary) >> size_diff, 8 bits, modulo; the result is meaningful only when wrap_split = 1.
  - len_offset = (a_addr_in & (DATA_WIDTH_OUT/8 - 1)) >> a_size_in.
  - out_len:
    - FIXED: a_len_in.
    - WRAP, not split: a_len_in >> size_diff.
    - INCR: (len_offset + a_len_in) >> size_diff, computed at 9 bits and truncated to 8.
- Push = a_valid_in & a_ready_out. Pop = a_valid_out & a_ready_in.
- Storage is a register array with wr_ptr, rd_ptr and count; the pointers wrap modulo DEPTH.
- a_ready_out is registered and equals (count_next < DEPTH). It does not depend combinationally on a_ready_in, so a push is never accepted while full, even if a pop occurs in the same cycle.
- a_valid_out = (count != 0). All *_out fields are driven from the entry at rd_ptr.
- Latency: a beat pushed in cycle N appears on the outputs in cycle N+1 if the FIFO was empty. Throughput is 1 per cycle when DEPTH >= 2.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pop when empty and push when full cannot occur by construction.
- Outputs are held stable while a_valid_out = 1 and a_ready_in = 0.
- Reset, including mid-operation:
  - count, wr_ptr and rd_ptr clear to 0, and in-flight entries are discarded.
  - a_valid_out = 0 and a_ready_out = 0 while rst is high. a_ready_out rises at the first clk edge after release.
  - Storage is not reset. *_out fields read storage entry 0 while empty and are don't-care when a_valid_out = 0.

Test Plan:
All cases use DATA_WIDTH_IN = 32, DATA_WIDTH_OUT = 128, DEPTH = 4.
1. Aligned WRAP, ALEN=3, ASIZE=2, ADDR=0x100 -> next cycle: valid=1, mask=0x00F, wrap_split=0, to_boundary=4, size_diff=2, len_offset=0, out_len=0.
2. Unaligned WRAP, ALEN=3, ASIZE=2, ADDR=0x108 -> to_boundary=2, wrap_split=1, alen_wrap=0, alen_sec_wrap=0, len_offset=2.
3. INCR, ALEN=7, ASIZE=2, ADDR=0x0C -> len_offset=3, out_len=2, fixed=0. FIXED, ALEN=5 -> fixed=1, out_len=5.
4. Full handling, a_ready_in=0, five consecutive valids -> four accepted, a_ready_out=0 from the cycle after the 4th push, count_out=4, fifth held. Then a_ready_in=1 for one cycle -> entry 1 popped, fifth accepted the following cycle, outputs in order.
5. FIFO at count=2 with push and pop in the same cycle for 10 cycles -> count_out stays 2, no loss or duplication, order preserved.
6. rst asserted asynchronously with count=3 -> a_valid_out=0 and count_out=0 immediately. After release, a_ready_out=1 at the next edge and the first new push is the first output.
